// File: rtl/addsub_signed_chunked.sv
// addsub_signed_chunked: multi-cycle signed add/sub that processes CHUNK bits
// per clock through one shared CHUNK-bit carry stage, with a start/busy/done
// handshake, optional saturation and a sticky overflow flag.
module addsub_signed_chunked #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             add_n,
    input  logic             sat_en,
    input  logic             clr_sticky,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             ovf_sticky
);

    localparam int unsigned N        = WIDTH / CHUNK;
    localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic             carry_q;
    logic             sat_q;

    logic [CHUNK-1:0] a_chunk_c;
    logic [CHUNK-1:0] b_chunk_c;
    logic [CHUNK:0]   sum_c;
    logic [WIDTH-1:0] raw_c;
    logic             ovf_c;
    logic             last_c;
    logic [WIDTH-1:0] sat_val_c;

    // Current chunk sum, full partial sum including it, and overflow/clamp values
    always_comb begin
        a_chunk_c = a_q[idx*CHUNK +: CHUNK];
        b_chunk_c = b_q[idx*CHUNK +: CHUNK];
        sum_c     = {1'b0, a_chunk_c} + {1'b0, b_chunk_c} + {{CHUNK{1'b0}}, carry_q};
        raw_c     = part_q;
        raw_c[idx*CHUNK +: CHUNK] = sum_c[CHUNK-1:0];
        ovf_c     = (a_q[WIDTH-1] & b_q[WIDTH-1] & ~raw_c[WIDTH-1]) |
                    (~a_q[WIDTH-1] & ~b_q[WIDTH-1] & raw_c[WIDTH-1]);
        last_c    = (state == RUN) && (idx == LAST_IDX);
        sat_val_c = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Control FSM, chunk datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            part_q     <= '0;
            carry_q    <= 1'b0;
            sat_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            cout       <= 1'b0;
            overflow   <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= x;
                        b_q     <= y ^ {WIDTH{add_n}};
                        carry_q <= add_n;
                        sat_q   <= sat_en;
                        idx     <= '0;
                        part_q  <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    part_q  <= raw_c;
                    carry_q <= sum_c[CHUNK];
                    if (idx == LAST_IDX) begin
                        cout     <= sum_c[CHUNK];
                        overflow <= ovf_c;
                        result   <= (ovf_c && sat_q) ? sat_val_c : raw_c;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Sticky overflow: a completing overflow wins over a clear
            if (last_c && ovf_c) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: doc/addsub_signed_chunked.md
# addsub_signed_chunked

Multi-cycle signed adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock through one shared CHUNK-bit carry stage. It adds a start/busy/done handshake, optional saturation, and a sticky overflow flag. It is the area-reduced successor to the single-cycle signed add/sub, for wide datapaths where one full-width ripple chain would not close timing.

## Interface
- WIDTH, 16: operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4: bits added per cycle; N = WIDTH/CHUNK chunk cycles per operation.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- x  in  WIDTH  signed operand A; captured with start.
- y  in  WIDTH  signed operand B; captured with start.
- add_n  in  1  0 = x+y, 1 = x−y; captured with start.
- sat_en  in  1  1 = clamp result on overflow; captured with start.
- clr_sticky  in  1  clears ovf_sticky.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result/cout/overflow update.
- result  out  WIDTH  final (possibly saturated) result; holds between operations.
- cout  out  1  raw carry out of the MSB (unsaturated).
- overflow  out  1  signed overflow of the completed operation.
- ovf_sticky  out  1  set by any completed operation with overflow.

## Operation
- State machine with two states:
  - IDLE: busy=0.
  - RUN: busy=1, chunk index idx runs 0..N−1.
- Accepting a start (IDLE with start=1, at the clock edge):
  - Capture a=x, b=y^{WIDTH{add_n}}, carry=add_n, sat=sat_en.
  - Set idx=0 and go to RUN.
- Each RUN edge:
  - Compute sum chunk {c, s} = a[idx] + b[idx] + carry, where a[idx] is bits idx*CHUNK .. idx*CHUNK+CHUNK−1.
  - Write s into the internal partial register and update carry=c.
- Last RUN edge (idx=N−1):
  - raw = full partial sum including this chunk.
  - ovf = (a[W−1] & b[W−1] & ~raw[W−1]) | (~a[W−1] & ~b[W−1] & raw[W−1]).
  - cout <= final carry; overflow <= ovf.
  - result <= ovf & sat ? (a[W−1] ? 1 followed by W−1 zeros : 0 followed by W−1 ones) : raw.
  - done <= 1; state returns to IDLE.
- Outputs result, cout and overflow change only on the done edge. Partial sums are never visible.
- overflow still reports 1 when saturation is applied. cout is always the unsaturated carry.
- ovf_sticky:
  - Set on the done edge if ovf=1.
  - Otherwise cleared when clr_sticky=1.
  - If set and clear occur in the same edge, set wins.
- start while busy=1 is ignored; there is no queueing.
- Arithmetic is two's complement, modulo 2^WIDTH, with no widening.

## Timing
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0, ovf_sticky=0, internal registers 0.
- Start accepted at edge E: busy=1 from E until edge E+N. done=1 for exactly the cycle after edge E+N, with valid outputs in that cycle.
- Latency is N edges, start to done. For the default parameters, N=4.
- Back-to-back: start asserted in the same cycle done is high is accepted at that edge. Sustained throughput is one operation per N cycles.
- Reset asserted mid-operation aborts immediately:
  - No done pulse.
  - result, cout, overflow and ovf_sticky return to 0.
  - The next operation is accepted normally after reset deasserts.
- CHUNK=WIDTH is legal: N=1, and done follows start by one edge.
- Operand inputs may change freely after the accepting edge.

## Test plan
- **Add:** WIDTH=16, CHUNK=4; x=0x1234, y=0x0101, add_n=0 -> done 4 edges after start; result=0x1335, cout=0, overflow=0; busy high for exactly 4 cycles.
- **Subtract:** x=0x0005, y=0x0007, add_n=1 -> result=0xFFFE, cout=0, overflow=0.
- **Positive overflow:** x=0x7FFF, y=0x0001, add_n=0.
  - sat_en=0 -> result=0x8000, overflow=1, cout=0, ovf_sticky=1.
  - Repeat with sat_en=1 -> result=0x7FFF, overflow=1.
- **Negative overflow, saturated:** x=0x8000, y=0x0001, add_n=1, sat_en=1 -> raw 0x7FFF; result=0x8000, overflow=1, cout=1.
- **Handshake:**
  - start pulsed again at edges E+1..E+3 -> ignored; single done at E+4.
  - start held during the done cycle -> second operation accepted; its done arrives 4 edges later.
  - clr_sticky in the same edge as an overflowing done -> ovf_sticky stays 1.
- **Reset mid-operation:** rst asserted 2 edges after start -> busy=0 and all outputs 0 at once; no done. After release, 0x0003+0x0004 -> result=0x0007 after 4 edges.
